// File: rtl/lcd_frame_arbiter.sv
// rtl/lcd_frame_arbiter.sv - round-robin packet arbiter for the LCD pixel FIFO write side
module lcd_frame_arbiter #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic               wrclk,
    input  logic               wrreset_n,
    input  logic               arb_enable,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [EMPTY_W-1:0] in0_empty,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [EMPTY_W-1:0] in1_empty,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic               in1_valid,
    output logic               in1_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         grant,
    output logic [15:0]        frame_count,
    output logic [15:0]        drop_count,
    output logic [7:0]         abort_count
);

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

    state_t      state;
    logic        last_grant;
    logic [15:0] stall_cnt;

    logic        cand0;
    logic        cand1;
    logic        pick1;
    logic        drop0;
    logic        drop1;
    logic        cur_src;
    logic        sel_valid;
    logic        sel_eop;
    logic [16:0] drop_sum;

    assign cand0     = in0_valid & in0_sop;
    assign cand1     = in1_valid & in1_sop;
    // Source 1 wins when it is the only candidate, or when both contend and source 0 owned last.
    assign pick1     = cand1 & (~cand0 | ~last_grant);
    assign drop0     = (state == IDLE) & in0_valid & ~in0_sop;
    assign drop1     = (state == IDLE) & in1_valid & ~in1_sop;
    assign cur_src   = (state == GRANT1);
    assign sel_valid = cur_src ? in1_valid : in0_valid;
    assign sel_eop   = cur_src ? in1_eop : in0_eop;
    assign drop_sum  = {1'b0, drop_count} + 17'(drop0) + 17'(drop1);

    // Zero-latency beat mux and ready steering; sources are held off while reset is asserted.
    always_comb begin
        out_data  = '0;
        out_empty = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_valid = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state)
            IDLE: begin
                in0_ready = drop0 & wrreset_n;
                in1_ready = drop1 & wrreset_n;
            end
            GRANT0: begin
                out_data  = in0_data;
                out_empty = in0_empty;
                out_sop   = in0_sop;
                out_eop   = in0_eop;
                out_valid = in0_valid;
                in0_ready = out_ready;
            end
            GRANT1: begin
                out_data  = in1_data;
                out_empty = in1_empty;
                out_sop   = in1_sop;
                out_eop   = in1_eop;
                out_valid = in1_valid;
                in1_ready = out_ready;
            end
            ABORT: begin
                out_valid = 1'b1;
                out_eop   = 1'b1;
            end
            default: ;
        endcase
    end

    // Ownership FSM, stall watchdog and statistics counters.
    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_grant  <= 1'b1;
            stall_cnt   <= '0;
            frame_count <= '0;
            drop_count  <= '0;
            abort_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case (state)
                IDLE: begin
                    if (arb_enable && (cand0 || cand1)) begin
                        state     <= pick1 ? GRANT1 : GRANT0;
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        stall_cnt <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (sel_valid && out_ready) begin
                        stall_cnt <= '0;
                        if (sel_eop) begin
                            state       <= IDLE;
                            grant       <= 2'b00;
                            last_grant  <= cur_src;
                            frame_count <= frame_count + 16'd1;
                        end
                    end else if (!sel_valid) begin
                        if (stall_cnt == STALL_LIMIT) begin
                            // last_grant is recorded here; nothing reads it before ABORT ends.
                            state      <= ABORT;
                            grant      <= 2'b00;
                            last_grant <= cur_src;
                            if (abort_count != 8'hFF) begin
                                abort_count <= abort_count + 8'd1;
                            end
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                ABORT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
